// File: rtl/keypad_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_pkg : scan states and column-pattern helpers for the keypad scanner
// Revision   : 1.0
// ---------------------------------------------------------------------------
package keypad_pkg;

   localparam int MAX_COLS = 32;

   typedef enum logic [1:0] {
      SCAN    = 2'd0,
      CONFIRM = 2'd1,
      RELEASE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      ZERO_LOW = 2'd0,
      ONE_LOW  = 2'd1,
      MANY_LOW = 2'd2
   } low_cnt_e;

   // Callers pad unused upper columns with ones so they never count as closed.
   function automatic low_cnt_e onehot_cnt(input logic [MAX_COLS-1:0] col_n);
      int       n;
      low_cnt_e res;
      n = 0;
      for (int i = 0; i < MAX_COLS; i++) begin
         if (!col_n[i]) n = n + 1;
      end
      if (n == 0)      res = ZERO_LOW;
      else if (n == 1) res = ONE_LOW;
      else             res = MANY_LOW;
      return res;
   endfunction

   function automatic logic [4:0] col_index(input logic [MAX_COLS-1:0] col_n);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_COLS; i++) begin
         if (!col_n[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_matrix_scanner_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_matrix_scanner_if : key-code valid/ready channel plus event pulses
// Revision                 : 1.0
// ---------------------------------------------------------------------------
interface keypad_matrix_scanner_if #(
   parameter int CODE_W = 4
);
   logic [CODE_W-1:0] key_code;
   logic              key_valid;
   logic              key_ready;
   logic              multi_key;
   logic              overrun;

   modport master (
      output key_code, key_valid, multi_key, overrun,
      input  key_ready
   );

   modport slave (
      input  key_code, key_valid, multi_key, overrun,
      output key_ready
   );
endinterface
`default_nettype wire

// File: rtl/keypad_row_sweeper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_row_sweeper : row dwell counter, row index ring and active-low drive
// Revision           : 1.0
// ---------------------------------------------------------------------------
module keypad_row_sweeper #(
   parameter int ROWS     = 4,
   parameter int SCAN_DIV = 50000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    advance_i,
   input  logic                    hold_i,
   output logic                    sample_tick_o,
   output logic [$clog2(ROWS)-1:0] row_idx_o,
   output logic [ROWS-1:0]         row_o
);
   localparam int                IDX_W    = $clog2(ROWS);
   localparam int                CNT_W    = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  ROW_LAST = IDX_W'(ROWS - 1);

   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [IDX_W-1:0] row_idx_q, row_idx_d;

   always_comb begin
      sample_tick_o = (dwell_q == CNT_LAST);
      dwell_d       = sample_tick_o ? '0 : dwell_q + CNT_W'(1);
      row_idx_d     = row_idx_q;
      if (sample_tick_o && advance_i && !hold_i) begin
         row_idx_d = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         dwell_q   <= '0;
         row_idx_q <= '0;
      end else begin
         dwell_q   <= dwell_d;
         row_idx_q <= row_idx_d;
      end
   end

   assign row_idx_o = row_idx_q;
   assign row_o     = ~(ROWS'(1) << row_idx_q);

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_matrix_scanner : row-sweep keypad reader with debounce and handshake
// Revision              : 1.0
// ---------------------------------------------------------------------------
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [COLS-1:0]         col,
   output logic [ROWS-1:0]         row,
   keypad_matrix_scanner_if.master kbus
);
   localparam int                 CODE_W    = $clog2(ROWS * COLS);
   localparam int                 IDX_W     = $clog2(ROWS);
   localparam int                 CIDX_W    = $clog2(COLS);
   localparam int                 SCNT_W    = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SCNT_W-1:0]  SCNT_LAST = SCNT_W'(DEBOUNCE_SCANS);

   state_e              state_q, state_d;
   logic [COLS-1:0]     pat_q, pat_d;
   logic [CIDX_W-1:0]   cidx_q, cidx_d;
   logic [SCNT_W-1:0]   scnt_q, scnt_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                valid_q, valid_d;
   logic                multi_q, multi_d;
   logic                over_q, over_d;
   logic                advance, hold, accept, tick;
   logic [IDX_W-1:0]    row_idx;
   logic [MAX_COLS-1:0] col_pad;
   low_cnt_e            lows;

   keypad_row_sweeper #(
      .ROWS     (ROWS),
      .SCAN_DIV (SCAN_DIV)
   ) u_sweeper (
      .clk           (clk),
      .rst           (rst),
      .advance_i     (advance),
      .hold_i        (hold),
      .sample_tick_o (tick),
      .row_idx_o     (row_idx),
      .row_o         (row)
   );

   always_comb begin
      col_pad             = '1;
      col_pad[COLS-1:0]   = col;
      lows                = onehot_cnt(col_pad);
      state_d             = state_q;
      pat_d               = pat_q;
      cidx_d              = cidx_q;
      scnt_d              = scnt_q;
      advance             = 1'b0;
      hold                = (state_q != SCAN);
      accept              = 1'b0;
      multi_d             = 1'b0;
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (lows == ONE_LOW) begin
                  pat_d  = col;
                  cidx_d = CIDX_W'(col_index(col_pad));
                  hold   = 1'b1;
                  if (DEBOUNCE_SCANS == 1) begin
                     accept  = 1'b1;
                     scnt_d  = '0;
                     state_d = RELEASE;
                  end else begin
                     scnt_d  = SCNT_W'(1);
                     state_d = CONFIRM;
                  end
               end else begin
                  advance = 1'b1;
                  multi_d = (lows == MANY_LOW);
               end
            end
            CONFIRM: begin
               if (col == pat_q) begin
                  if (scnt_q + SCNT_W'(1) == SCNT_LAST) begin
                     accept  = 1'b1;
                     scnt_d  = '0;
                     state_d = RELEASE;
                  end else begin
                     scnt_d = scnt_q + SCNT_W'(1);
                  end
               end else begin
                  multi_d = (lows == MANY_LOW);
                  advance = 1'b1;
                  hold    = 1'b0;
                  state_d = SCAN;
               end
            end
            RELEASE: begin
               if (lows == ZERO_LOW) begin
                  if (scnt_q + SCNT_W'(1) == SCNT_LAST) begin
                     advance = 1'b1;
                     hold    = 1'b0;
                     scnt_d  = '0;
                     state_d = SCAN;
                  end else begin
                     scnt_d = scnt_q + SCNT_W'(1);
                  end
               end else begin
                  scnt_d = '0;
               end
            end
            default: state_d = SCAN;
         endcase
      end

      // A handshake on this edge frees the slot before the accept decision.
      valid_d = valid_q & ~kbus.key_ready;
      code_d  = code_q;
      over_d  = 1'b0;
      if (accept) begin
         if (valid_d) begin
            over_d = 1'b1;
         end else begin
            code_d  = CODE_W'(row_idx) * CODE_W'(COLS) + CODE_W'(cidx_d);
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= SCAN;
         pat_q   <= '1;
         cidx_q  <= '0;
         scnt_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
         over_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         cidx_q  <= cidx_d;
         scnt_q  <= scnt_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         multi_q <= multi_d;
         over_q  <= over_d;
      end
   end

   assign kbus.key_code  = code_q;
   assign kbus.key_valid = valid_q;
   assign kbus.multi_key = multi_q;
   assign kbus.overrun   = over_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_keypad_matrix_scanner : directed vector table plus random keypad traffic
// Revision                 : 1.0
// ---------------------------------------------------------------------------
module tb_keypad_matrix_scanner;
   localparam int ROWS     = 4;
   localparam int COLS     = 4;
   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;
   localparam int NKEYS    = ROWS * COLS;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [COLS-1:0] col = '1;
   logic [ROWS-1:0] row;

   keypad_matrix_scanner_if #(.CODE_W(4)) kbus ();

   keypad_matrix_scanner #(
      .ROWS           (ROWS),
      .COLS           (COLS),
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEB)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .col  (col),
      .row  (row),
      .kbus (kbus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [NKEYS-1:0] keys = '0;

   // Reference keypad reader: tracks time in the row dwell, which row is lit,
   // the column being confirmed, and how long the pad has been quiet.
   int m_dwell = 0, m_row = 0, m_cand = -1, m_seen = 0, m_quiet = 0, m_code = 0;
   bit m_locked = 0, m_valid = 0, e_multi = 0, e_over = 0;

   typedef struct {
      bit               rst_n;
      logic [NKEYS-1:0] keys;
      bit               rdy;
      int               cycles;
      logic [ROWS-1:0]  row;
      bit               valid;
      logic [3:0]       code;
      bit               multi;
      bit               over;
   } vec_t;

   vec_t tbl[23];

   function automatic logic [COLS-1:0] keypad_cols(input int r, input logic [NKEYS-1:0] k);
      logic [COLS-1:0] c;
      for (int i = 0; i < COLS; i++) c[i] = ~k[r * COLS + i];
      return c;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_edge(input bit rst_n, input logic [COLS-1:0] c, input bit rdy);
      int lows, idx;
      bit acc, v;
      if (!rst_n) begin
         m_dwell = 0; m_row = 0; m_cand = -1; m_seen = 0; m_quiet = 0;
         m_code = 0; m_locked = 0; m_valid = 0; e_multi = 0; e_over = 0;
         return;
      end
      e_multi = 0; e_over = 0; acc = 0;
      v = m_valid && !rdy;
      if (m_dwell == SCAN_DIV - 1) begin
         lows = 0; idx = 0;
         for (int i = 0; i < COLS; i++) if (!c[i]) begin lows++; idx = i; end
         if (m_locked) begin
            m_quiet = (lows == 0) ? m_quiet + 1 : 0;
            if (m_quiet == DEB) begin m_locked = 0; m_row = (m_row + 1) % ROWS; end
         end else if (m_cand >= 0) begin
            if (lows == 1 && idx == m_cand) m_seen++;
            else begin
               e_multi = (lows > 1);
               m_cand  = -1;
               m_row   = (m_row + 1) % ROWS;
            end
         end else if (lows == 1) begin
            m_cand = idx; m_seen = 1;
         end else begin
            e_multi = (lows > 1);
            m_row   = (m_row + 1) % ROWS;
         end
         if (m_cand >= 0 && m_seen == DEB) begin
            acc = 1;
            if (!v) m_code = m_row * COLS + m_cand;
            m_cand = -1; m_locked = 1; m_quiet = 0;
         end
      end
      if (acc) begin
         if (v) e_over = 1;
         else   v = 1;
      end
      m_valid = v;
      m_dwell = (m_dwell + 1) % SCAN_DIV;
   endtask

   task automatic step(input bit rst_n, input bit rdy);
      logic [COLS-1:0] c;
      logic [ROWS-1:0] er;
      c = keypad_cols(m_row, keys);
      rst = rst_n; col = c; kbus.key_ready = rdy;
      @(posedge clk);
      model_edge(rst_n, c, rdy);
      #1;
      cyc++;
      er = ~(ROWS'(1) << m_row);
      chk("row", row, er);
      chk("key_valid", kbus.key_valid, m_valid);
      chk("key_code", kbus.key_code, m_code);
      chk("multi_key", kbus.multi_key, e_multi);
      chk("overrun", kbus.overrun, e_over);
   endtask

   initial begin
      kbus.key_ready = 1'b0;
      //         rst keys       rdy cyc  row      vld code multi over
      tbl[0]  = '{0, 16'h0000,  0,  2,  4'b1110, 0, 0, 0, 0};
      tbl[1]  = '{1, 16'h0000,  0,  3,  4'b1110, 0, 0, 0, 0};
      tbl[2]  = '{1, 16'h0000,  0,  1,  4'b1101, 0, 0, 0, 0};
      tbl[3]  = '{1, 16'h0000,  0,  4,  4'b1011, 0, 0, 0, 0};
      tbl[4]  = '{1, 16'h0000,  0,  4,  4'b0111, 0, 0, 0, 0};
      tbl[5]  = '{1, 16'h0000,  0,  4,  4'b1110, 0, 0, 0, 0};
      tbl[6]  = '{1, 16'h0200,  0, 20,  4'b1011, 1, 9, 0, 0};
      tbl[7]  = '{1, 16'h0200,  0,  8,  4'b1011, 1, 9, 0, 0};
      tbl[8]  = '{1, 16'h0200,  1,  1,  4'b1011, 0, 9, 0, 0};
      tbl[9]  = '{1, 16'h0000,  0, 11,  4'b0111, 0, 9, 0, 0};
      tbl[10] = '{1, 16'h0200,  0, 16,  4'b1011, 0, 9, 0, 0};
      tbl[11] = '{1, 16'h0000,  0,  4,  4'b0111, 0, 9, 0, 0};
      tbl[12] = '{1, 16'h0003,  0,  8,  4'b1101, 0, 9, 1, 0};
      tbl[13] = '{1, 16'h0000,  0,  1,  4'b1101, 0, 9, 0, 0};
      tbl[14] = '{1, 16'h0001,  0, 23,  4'b1110, 1, 0, 0, 0};
      tbl[15] = '{1, 16'h0000,  0, 12,  4'b1101, 1, 0, 0, 0};
      tbl[16] = '{1, 16'h0020,  0, 12,  4'b1101, 1, 0, 0, 1};
      tbl[17] = '{1, 16'h0020,  0, 80,  4'b1101, 1, 0, 0, 0};
      tbl[18] = '{1, 16'h0000,  1,  1,  4'b1101, 0, 0, 0, 0};
      tbl[19] = '{0, 16'h0000,  0,  2,  4'b1110, 0, 0, 0, 0};
      tbl[20] = '{1, 16'h0200,  0, 16,  4'b1011, 0, 0, 0, 0};
      tbl[21] = '{0, 16'h0200,  0,  1,  4'b1110, 0, 0, 0, 0};
      tbl[22] = '{1, 16'h0000,  0, 40,  4'b1011, 0, 0, 0, 0};

      for (int i = 0; i < 23; i++) begin
         keys = tbl[i].keys;
         repeat (tbl[i].cycles) step(tbl[i].rst_n, tbl[i].rdy);
         chk($sformatf("vec%0d_row", i), row, tbl[i].row);
         chk($sformatf("vec%0d_valid", i), kbus.key_valid, tbl[i].valid);
         chk($sformatf("vec%0d_code", i), kbus.key_code, tbl[i].code);
         chk($sformatf("vec%0d_multi", i), kbus.multi_key, tbl[i].multi);
         chk($sformatf("vec%0d_over", i), kbus.overrun, tbl[i].over);
      end

      keys = '0;
      repeat (2) step(0, 0);
      for (int p = 0; p < 160; p++) begin
         int sel, k, r, dur;
         sel = $urandom_range(0, 9);
         k   = $urandom_range(0, NKEYS - 1);
         r   = k / COLS;
         if (sel < 4)       keys = '0;
         else if (sel < 9)  keys = NKEYS'(1) << k;
         else               keys = (NKEYS'(1) << k) | (NKEYS'(1) << (r * COLS + (k + 1) % COLS));
         dur = $urandom_range(1, 40);
         for (int c = 0; c < dur; c++) step(1, $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 39) == 0) step(0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
